mac512_r4_rca: RTL and testbench



---
 rtl/mac512_r4_rca_if.sv | 30 +++
 rtl/mac512_r4_rca.sv | 149 ++++++++++++++
 tb/tb_mac512_r4_rca.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mac512_r4_rca_if.sv
`default_nettype none
// ============================================================================
// Module   : mac512_r4_rca_if
// Brief    : Operand/result bundle for the radix-4 ripple-carry MAC.
//            Master drives en/A/B and observes out; slave is the MAC.
// Revision : 1.0 - initial release
// ============================================================================
interface mac512_r4_rca_if #(
    parameter int WIDTH = 256
) ();
    logic                 en;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   out;

    modport master (
        output en,
        output A,
        output B,
        input  out
    );

    modport slave (
        input  en,
        input  A,
        input  B,
        output out
    );
endinterface : mac512_r4_rca_if
`default_nettype wire

// File: rtl/mac512_r4_rca.sv
`default_nettype none
// ============================================================================
// Module   : mac512_r4_rca
// Brief    : Iterative radix-4 unsigned multiply-accumulate. Each 130-cycle
//            pass (LOAD, WIDTH/2 x ITER, ACC) samples A/B, forms A*B two
//            multiplier bits per cycle with ripple-carry adders and adds the
//            product into the 2*WIDTH-bit accumulator. en=0 freezes all state.
//            Optional macro MAC512_SAT_EN: accumulator saturates to all-ones
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module mac512_r4_rca #(
    parameter int WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac512_r4_rca_if.slave       bus
);

    localparam int PW    = 2*WIDTH + 2;   // partial-product width
    localparam int OW    = 2*WIDTH;       // accumulator width
    localparam int ITERS = WIDTH / 2;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(ITERS - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    // Bit-serial carry chain; written out explicitly so every add is a true
    // ripple-carry structure. Carry-out is dropped: callers size operands so
    // the sum never exceeds PW bits.
    function automatic logic [PW-1:0] rca_add(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y);
        logic          c;
        logic [PW-1:0] s;
        c = 1'b0;
        for (int i = 0; i < PW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [PW-1:0]    a_sh_q,  a_sh_d;    // Areg << 2k
    logic [PW-1:0]    a3_sh_q, a3_sh_d;   // 3*Areg << 2k
    logic [WIDTH-1:0] b_q,     b_d;       // Breg >> 2k, current digit in [1:0]
    logic [PW-1:0]    p_q,     p_d;
    logic [OW-1:0]    out_q,   out_d;

    logic [PW-1:0]    a3_w;
    logic [PW-1:0]    mult_sel;
    logic [PW-1:0]    pp_sum;
    logic [PW-1:0]    acc_sum;
    logic             unused_bits;

    // 3A is formed as A + 2A so no multiplier is needed for the odd multiple.
    assign a3_w    = rca_add(PW'(bus.A), PW'({bus.A, 1'b0}));
    assign pp_sum  = rca_add(p_q, mult_sel);
    assign acc_sum = rca_add({2'b00, out_q}, {2'b00, p_q[OW-1:0]});

    assign bus.out = out_q;

    // Bits that exist for headroom only and never feed a result.
    assign unused_bits = ^{p_q[PW-1:OW], acc_sum[PW-1:OW], a_sh_q[PW-1:PW-2]};

    // Radix-4 digit picks one of the four precomputed, pre-shifted multiples.
    always_comb begin
        mult_sel = '0;
        case (b_q[1:0])
            2'd0:    mult_sel = '0;
            2'd1:    mult_sel = a_sh_q;
            2'd2:    mult_sel = {a_sh_q[PW-2:0], 1'b0};
            default: mult_sel = a3_sh_q;
        endcase
    end

    // State register plus datapath registers; en=0 holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            a3_sh_q <= '0;
            b_q     <= '0;
            p_q     <= '0;
            out_q   <= '0;
        end else if (bus.en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            a3_sh_q <= a3_sh_d;
            b_q     <= b_d;
            p_q     <= p_d;
            out_q   <= out_d;
        end
    end

    // Next-state sequencing: LOAD -> ITER x ITERS -> ACC -> LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  state_d = S_ITER;
            S_ITER:  if (cnt_q == C_LAST) state_d = S_ACC;
            S_ACC:   state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // Per-state datapath updates; multiples shift left while Breg shifts
    // right, so the digit and its weight stay aligned without a barrel shifter.
    always_comb begin
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        a3_sh_d = a3_sh_q;
        b_d     = b_q;
        p_d     = p_q;
        out_d   = out_q;
        case (state_q)
            S_LOAD: begin
                a_sh_d  = PW'(bus.A);
                a3_sh_d = a3_w;
                b_d     = bus.B;
                p_d     = '0;
                cnt_d   = '0;
            end
            S_ITER: begin
                p_d     = pp_sum;
                a_sh_d  = {a_sh_q[PW-3:0], 2'b00};
                a3_sh_d = {a3_sh_q[PW-3:0], 2'b00};
                b_d     = {2'b00, b_q[WIDTH-1:2]};
                cnt_d   = cnt_q + CW'(1);
            end
            S_ACC: begin
`ifdef MAC512_SAT_EN
                out_d = acc_sum[OW] ? {OW{1'b1}} : acc_sum[OW-1:0];
`else
                out_d = acc_sum[OW-1:0];
`endif
            end
            default: ;
        endcase
    end

endmodule : mac512_r4_rca
`default_nettype wire

// File: tb/tb_mac512_r4_rca.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac512_r4_rca
// Brief    : Directed self-checking bench for mac512_r4_rca (WIDTH=256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac512_r4_rca;

    localparam int WIDTH = 256;
    localparam int OW    = 2*WIDTH;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mac512_r4_rca_if #(.WIDTH(WIDTH)) bus ();

    mac512_r4_rca #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [OW-1:0] obs,
                          input logic [OW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse with en held high to show reset dominates.
    task automatic do_reset(input string tag);
        bus.en = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk_eq(tag, bus.out, '0);
        tick(2);
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] ones_w;
    logic [WIDTH-1:0] b_dig;
    logic [OW-1:0]    exp_dig;
    logic [OW-1:0]    exp_ov1;
    logic [OW-1:0]    exp_ov2;
    logic [OW-1:0]    exp_ov3;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        bus.en = 1'b0;
        bus.A  = 256'd32;
        bus.B  = 256'd32;

        ones_w  = {WIDTH{1'b1}};
        b_dig   = {32{8'hE4}};
        // (2^256-1)*B = (B-1)*2^256 + (2^256-B)
        exp_dig = {{31{8'hE4}}, 8'hE3, {31{8'h1B}}, 8'h1C};
        // P = (2^256-1)^2 = 2^512 - 2^257 + 1, then 2P and 3P mod 2^512
        exp_ov1 = {{255{1'b1}}, 1'b0, 256'd1};
`ifdef MAC512_SAT_EN
        exp_ov2 = {OW{1'b1}};
        exp_ov3 = {OW{1'b1}};
`else
        exp_ov2 = {{254{1'b1}}, 258'd2};
        exp_ov3 = {{253{1'b1}}, 1'b0, 1'b1, 257'd3};
`endif

        // Reset asserted mid-cycle, checked immediately and while held.
        #3;
        rst_n = 1'b0;
        #1;
        chk_eq("reset_async", bus.out, '0);
        bus.en = 1'b1;
        tick(3);
        chk_eq("reset_hold", bus.out, '0);
        rst_n = 1'b1;

        // Basic accumulate 32*32.
        tick(129);
        chk_eq("acc1_before", bus.out, 512'd0);
        tick(1);
        chk_eq("acc1", bus.out, 512'd1024);
        tick(129);
        chk_eq("acc2_before", bus.out, 512'd1024);
        tick(1);
        chk_eq("acc2", bus.out, 512'd2048);
        tick(130);
        chk_eq("acc3", bus.out, 512'd3072);

        // Operand change during ITER is ignored until next LOAD.
        tick(10);
        bus.A = 256'd5;
        bus.B = 256'd10;
        tick(120);
        chk_eq("opchg_cur", bus.out, 512'd4096);
        tick(130);
        chk_eq("opchg_next", bus.out, 512'd4146);
        bus.A = 256'd100;
        bus.B = 256'd100;
        tick(130);
        chk_eq("op100_1", bus.out, 512'd14146);
        tick(130);
        chk_eq("op100_2", bus.out, 512'd24146);

        // Enable stall of 37 cycles mid-ITER.
        bus.A = 256'd32;
        bus.B = 256'd32;
        do_reset("stall_reset");
        tick(50);
        bus.en = 1'b0;
        tick(37);
        chk_eq("stall_hold", bus.out, 512'd0);
        bus.en = 1'b1;
        tick(79);
        chk_eq("stall_before", bus.out, 512'd0);
        tick(1);
        chk_eq("stall_acc", bus.out, 512'd1024);

        // All four radix-4 digits against an all-ones multiplicand.
        bus.A = ones_w;
        bus.B = b_dig;
        do_reset("digit_reset");
        tick(129);
        chk_eq("digit_before", bus.out, 512'd0);
        tick(1);
        chk_eq("digit_prod", bus.out, exp_dig);

        // Repeated max operands: wrap or saturate.
        bus.A = ones_w;
        bus.B = ones_w;
        do_reset("ovf_reset");
        tick(130);
        chk_eq("ovf_1", bus.out, exp_ov1);
        tick(130);
        chk_eq("ovf_2", bus.out, exp_ov2);
        tick(130);
        chk_eq("ovf_3", bus.out, exp_ov3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mac512_r4_rca
`default_nettype wire
